decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: field extraction, 8x16 register file with write-through read,
// load-use stall / halt / flush control FSM and the decode/execute pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instruction,
    input  logic        i_flush,
    input  logic        i_wb_en,
    input  logic [2:0]  i_wb_addr,
    input  logic [15:0] i_wb_data,
    output logic        o_fetch_en,
    output logic [1:0]  o_pc_select,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [4:0]  o_opcode,
    output logic [2:0]  o_rdst,
    output logic [15:0] o_rdata1,
    output logic [15:0] o_rdata2,
    output logic [15:0] o_imm,
    output logic        o_we,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_halted
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned DW     = 16;
    localparam int unsigned OPW    = 5;
    localparam int unsigned RAW    = 3;
    localparam int unsigned NREG   = 8;
    localparam int unsigned PSW    = 2;

    localparam logic [PSW-1:0] PC_HOLD = 2'b00;
    localparam logic [PSW-1:0] PC_INC2 = 2'b01;
    localparam logic [PSW-1:0] PC_INC4 = 2'b10;

    localparam logic [OPW-1:0] OP_NOP = 5'b00000;
    localparam logic [OPW-1:0] OP_HLT = 5'b01111;
    localparam logic [OPW-1:0] OP_LDD = 5'b11000;
    localparam logic [OPW-1:0] OP_STD = 5'b11001;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [OPW-1:0]  opcode;
        logic [RAW-1:0]  rdst;
        logic [DW-1:0]   rdata1;
        logic [DW-1:0]   rdata2;
        logic [DW-1:0]   imm;
        logic            we;
        logic            mem_read;
        logic            mem_write;
    } pipe_t;

    state_e          state_q, state_d;
    pipe_t           pipe_q, pipe_d;
    logic            fetch_en_q, fetch_en_d;
    logic [PSW-1:0]  pc_sel_q, pc_sel_d;
    logic            halted_q, halted_d;
    logic [DW-1:0]   rf_q [NREG];

    // Instruction word fields
    logic [OPW-1:0]  opcode;
    logic [RAW-1:0]  rdst;
    logic [RAW-1:0]  rsrc1;
    logic [RAW-1:0]  rsrc2;
    logic [DW-1:0]   imm_field;
    logic            unused_word_bits;

    assign opcode           = i_instruction[31:27];
    assign rdst             = i_instruction[26:24];
    assign rsrc1            = i_instruction[23:21];
    assign rsrc2            = i_instruction[20:18];
    assign imm_field        = i_instruction[15:0];
    assign unused_word_bits = ^i_instruction[17:16];

    // Opcode class decode
    logic is_alu, is_ctrl, is_immalu, is_mem_cls;
    logic is_nop, is_hlt, is_ldd, is_std, is_rsvd;
    logic two_word, uses_rs1, uses_rs2, writes_rd;

    always_comb begin
        is_alu     = (opcode[4:3] == 2'b00);
        is_ctrl    = (opcode[4:3] == 2'b01);
        is_immalu  = (opcode[4:3] == 2'b10);
        is_mem_cls = (opcode[4:3] == 2'b11);
        is_nop     = (opcode == OP_NOP);
        is_hlt     = (opcode == OP_HLT);
        is_ldd     = (opcode == OP_LDD);
        is_std     = (opcode == OP_STD);
        is_rsvd    = is_mem_cls && !is_ldd && !is_std;
        two_word   = opcode[4];
        uses_rs1   = is_alu || (is_ctrl && !is_hlt) || is_immalu || is_ldd || is_std;
        uses_rs2   = is_alu || is_std;
        writes_rd  = (is_alu && !is_nop) || is_immalu || is_ldd;
    end

    // Register file reads with write-through from the writeback port
    logic [DW-1:0] rd1_val;
    logic [DW-1:0] rd2_val;

    always_comb begin
        rd1_val = rf_q[rsrc1];
        rd2_val = rf_q[rsrc2];
        if (i_wb_en && (i_wb_addr == rsrc1)) begin
            rd1_val = i_wb_data;
        end
        if (i_wb_en && (i_wb_addr == rsrc2)) begin
            rd2_val = i_wb_data;
        end
    end

    // Load-use hazard against the load sitting in the execute register
    logic load_use;

    always_comb begin
        load_use = pipe_q.valid && pipe_q.mem_read &&
                   ((uses_rs1 && (pipe_q.rdst == rsrc1)) ||
                    (uses_rs2 && (pipe_q.rdst == rsrc2)));
    end

    // Fully decoded payload for a normal issue; reserved opcodes collapse to NOP
    pipe_t issue;

    always_comb begin
        issue           = '0;
        issue.valid     = 1'b1;
        issue.pc        = i_pc;
        issue.opcode    = is_rsvd ? OP_NOP : opcode;
        issue.rdst      = rdst;
        issue.rdata1    = rd1_val;
        issue.rdata2    = rd2_val;
        issue.imm       = two_word ? imm_field : DW'(0);
        issue.we        = writes_rd;
        issue.mem_read  = is_ldd;
        issue.mem_write = is_std;
    end

    // Next-state and next-output logic; bubble and hold are the defaults
    always_comb begin
        state_d    = state_q;
        pipe_d     = '0;
        fetch_en_d = 1'b0;
        pc_sel_d   = PC_HOLD;

        case (state_q)
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_RUN, ST_STALL: begin
                if (i_flush) begin
                    state_d    = ST_RUN;
                    fetch_en_d = 1'b1;
                end else if (is_hlt) begin
                    state_d = ST_HALT;
                end else if (load_use) begin
                    state_d = ST_STALL;
                end else begin
                    state_d    = ST_RUN;
                    pipe_d     = issue;
                    fetch_en_d = 1'b1;
                    pc_sel_d   = two_word ? PC_INC4 : PC_INC2;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pipe_q     <= '0;
            fetch_en_q <= 1'b0;
            pc_sel_q   <= PC_HOLD;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pipe_q     <= pipe_d;
            fetch_en_q <= fetch_en_d;
            pc_sel_q   <= pc_sel_d;
            halted_q   <= halted_d;
        end
    end

    // Register file write port; active in every state, reset wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (i_wb_en) begin
            rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    assign o_fetch_en  = fetch_en_q;
    assign o_pc_select = pc_sel_q;
    assign o_halted    = halted_q;
    assign o_valid     = pipe_q.valid;
    assign o_pc        = pipe_q.pc;
    assign o_opcode    = pipe_q.opcode;
    assign o_rdst      = pipe_q.rdst;
    assign o_rdata1    = pipe_q.rdata1;
    assign o_rdata2    = pipe_q.rdata2;
    assign o_imm       = pipe_q.imm;
    assign o_we        = pipe_q.we;
    assign o_mem_read  = pipe_q.mem_read;
    assign o_mem_write = pipe_q.mem_write;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, halt/reset sequence, then
// random stimulus against an instruction-level reference model.
module tb_decode_stage;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
        logic [31:0] pc;
        logic [31:0] instr;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  opcode;
        logic [2:0]  rdst;
        logic [15:0] rdata1;
        logic [15:0] rdata2;
        logic [15:0] imm;
        logic        we;
        logic        mem_read;
        logic        mem_write;
        logic        fetch_en;
        logic [1:0]  pc_sel;
        logic        halted;
    } out_t;

    typedef struct packed {
        in_t  s;
        out_t e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] i_pc;
    logic [31:0] i_instruction;
    logic        i_flush;
    logic        i_wb_en;
    logic [2:0]  i_wb_addr;
    logic [15:0] i_wb_data;
    logic        o_fetch_en;
    logic [1:0]  o_pc_select;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [4:0]  o_opcode;
    logic [2:0]  o_rdst;
    logic [15:0] o_rdata1;
    logic [15:0] o_rdata2;
    logic [15:0] o_imm;
    logic        o_we;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_rf [8];
    out_t        m_cur;
    vec_t        tbl [$];

    decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .i_pc         (i_pc),
        .i_instruction(i_instruction),
        .i_flush      (i_flush),
        .i_wb_en      (i_wb_en),
        .i_wb_addr    (i_wb_addr),
        .i_wb_data    (i_wb_data),
        .o_fetch_en   (o_fetch_en),
        .o_pc_select  (o_pc_select),
        .o_valid      (o_valid),
        .o_pc         (o_pc),
        .o_opcode     (o_opcode),
        .o_rdst       (o_rdst),
        .o_rdata1     (o_rdata1),
        .o_rdata2     (o_rdata2),
        .o_imm        (o_imm),
        .o_we         (o_we),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
        .o_halted     (o_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ins(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] r1, input logic [2:0] r2,
                                        input logic [15:0] imm);
        return {op, rd, r1, r2, 2'b00, imm};
    endfunction

    function automatic in_t mk_in(input logic r, input logic fl, input logic we,
                                  input logic [2:0] wa, input logic [15:0] wd,
                                  input logic [31:0] pc, input logic [31:0] instr);
        in_t s;
        s.rst = r; s.flush = fl; s.wb_en = we; s.wb_addr = wa; s.wb_data = wd;
        s.pc = pc; s.instr = instr;
        return s;
    endfunction

    function automatic out_t mk_out(input logic v, input logic [31:0] pc, input logic [4:0] op,
                                    input logic [2:0] rd, input logic [15:0] d1,
                                    input logic [15:0] d2, input logic [15:0] imm,
                                    input logic we, input logic mr, input logic mw,
                                    input logic fe, input logic [1:0] ps, input logic h);
        out_t e;
        e.valid = v; e.pc = pc; e.opcode = op; e.rdst = rd; e.rdata1 = d1; e.rdata2 = d2;
        e.imm = imm; e.we = we; e.mem_read = mr; e.mem_write = mw; e.fetch_en = fe;
        e.pc_sel = ps; e.halted = h;
        return e;
    endfunction

    function automatic out_t bub(input logic fe, input logic h);
        out_t e;
        e = '0;
        e.fetch_en = fe;
        e.halted = h;
        return e;
    endfunction

    task automatic add(input in_t s, input out_t e);
        vec_t v;
        v.s = s;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input out_t a, input out_t e);
        check({tag, ".valid"},     32'(a.valid),     32'(e.valid));
        check({tag, ".pc"},        a.pc,             e.pc);
        check({tag, ".opcode"},    32'(a.opcode),    32'(e.opcode));
        check({tag, ".rdst"},      32'(a.rdst),      32'(e.rdst));
        check({tag, ".rdata1"},    32'(a.rdata1),    32'(e.rdata1));
        check({tag, ".rdata2"},    32'(a.rdata2),    32'(e.rdata2));
        check({tag, ".imm"},       32'(a.imm),       32'(e.imm));
        check({tag, ".we"},        32'(a.we),        32'(e.we));
        check({tag, ".mem_read"},  32'(a.mem_read),  32'(e.mem_read));
        check({tag, ".mem_write"}, 32'(a.mem_write), 32'(e.mem_write));
        check({tag, ".fetch_en"},  32'(a.fetch_en),  32'(e.fetch_en));
        check({tag, ".pc_select"}, 32'(a.pc_sel),    32'(e.pc_sel));
        check({tag, ".halted"},    32'(a.halted),    32'(e.halted));
    endtask

    // Drive one cycle of inputs, let the clock edge pass, sample the outputs.
    task automatic step(input in_t s, output out_t a);
        rst = s.rst; i_flush = s.flush; i_wb_en = s.wb_en; i_wb_addr = s.wb_addr;
        i_wb_data = s.wb_data; i_pc = s.pc; i_instruction = s.instr;
        @(posedge clk);
        #1;
        a.valid = o_valid; a.pc = o_pc; a.opcode = o_opcode; a.rdst = o_rdst;
        a.rdata1 = o_rdata1; a.rdata2 = o_rdata2; a.imm = o_imm; a.we = o_we;
        a.mem_read = o_mem_read; a.mem_write = o_mem_write; a.fetch_en = o_fetch_en;
        a.pc_sel = o_pc_select; a.halted = o_halted;
    endtask

    // Instruction-level reference: what the decode/execute register shows after this cycle.
    task automatic model_step(input in_t s, output out_t e);
        logic [4:0]  op;
        logic [2:0]  rd, r1, r2;
        logic [15:0] v1, v2;
        bit          n1, n2, wr, ld, st, hlt, rsvd, hazard;
        op = s.instr[31:27]; rd = s.instr[26:24]; r1 = s.instr[23:21]; r2 = s.instr[20:18];
        n1 = 0; n2 = 0; wr = 0; ld = 0; st = 0; hlt = 0; rsvd = 0;
        case (op[4:3])
            2'b00: begin n1 = 1; n2 = 1; wr = (op != 5'd0); end
            2'b01: begin if (op == 5'd15) hlt = 1; else n1 = 1; end
            2'b10: begin n1 = 1; wr = 1; end
            default: begin
                if (op == 5'd24) begin n1 = 1; wr = 1; ld = 1; end
                else if (op == 5'd25) begin n1 = 1; n2 = 1; st = 1; end
                else rsvd = 1;
            end
        endcase
        v1 = (s.wb_en && s.wb_addr == r1) ? s.wb_data : m_rf[r1];
        v2 = (s.wb_en && s.wb_addr == r2) ? s.wb_data : m_rf[r2];
        hazard = m_cur.valid && m_cur.mem_read &&
                 ((n1 && m_cur.rdst == r1) || (n2 && m_cur.rdst == r2));
        e = '0;
        if (s.rst) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        end else begin
            if (m_cur.halted)      e.halted = 1'b1;
            else if (s.flush)      e.fetch_en = 1'b1;
            else if (hlt)          e.halted = 1'b1;
            else if (hazard)       e = '0;
            else begin
                e = mk_out(1'b1, s.pc, rsvd ? 5'd0 : op, rd, v1, v2,
                           op[4] ? s.instr[15:0] : 16'h0, wr, ld, st, 1'b1,
                           op[4] ? 2'b10 : 2'b01, 1'b0);
            end
            if (s.wb_en) m_rf[s.wb_addr] = s.wb_data;
        end
        m_cur = e;
    endtask

    function automatic logic [31:0] rand_instr();
        int unsigned r;
        logic [4:0]  op;
        r = $urandom_range(0, 99);
        if (r < 3)       op = 5'h0F;
        else if (r < 25) op = 5'h18;
        else if (r < 35) op = 5'h19;
        else if (r < 42) op = 5'h1A + 5'($urandom_range(0, 5));
        else if (r < 60) op = 5'($urandom_range(0, 7));
        else if (r < 75) op = 5'h08 + 5'($urandom_range(0, 6));
        else             op = 5'h10 + 5'($urandom_range(0, 7));
        return ins(op, 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
    endfunction

    initial begin
        out_t a;
        out_t e;
        in_t  s;

        // Directed table: reset override, bypass, load-use stall, flush, reserved, HLT
        add(mk_in(1, 1, 1, 3, 16'hFFFF, 32'h0, ins(5'h0F, 0, 0, 0, 0)), bub(0, 0));
        add(mk_in(0, 0, 0, 0, 16'h0, 32'h100, ins(5'h00, 0, 3, 3, 0)),
            mk_out(1, 32'h100, 5'h00, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1, 2'b01, 0));
        add(mk_in(0, 0, 1, 3, 16'h1234, 32'h102, ins(5'h00, 0, 0, 0, 0)),
            mk_out(1, 32'h102, 5'h00, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1, 2'b01, 0));
        add(mk_in(0, 0, 0, 0, 16'h0, 32'h104, ins(5'h01, 1, 3, 0, 0)),
            mk_out(1, 32'h104, 5'h01, 1, 16'h1234, 16'h0, 16'h0, 1, 0, 0, 1, 2'b01, 0));
        add(mk_in(0, 0, 0, 0, 16'h0, 32'h106, ins(5'h18, 2, 3, 0, 16'h0010)),
            mk_out(1, 32'h106, 5'h18, 2, 16'h1234, 16'h0, 16'h0010, 1, 1, 0, 1, 2'b10, 0));
        add(mk_in(0, 0, 1, 2, 16'h5555, 32'h10A, ins(5'h02, 4, 0, 2, 0)), bub(0, 0));
        add(mk_in(0, 0, 0, 0, 16'h0, 32'h10A, ins(5'h02, 4, 0, 2, 0)),
            mk_out(1, 32'h10A, 5'h02, 4, 16'h0, 16'h5555, 16'h0, 1, 0, 0, 1, 2'b01, 0));
        add(mk_in(0, 0, 0, 0, 16'h0, 32'h10C, ins(5'h18, 5, 0, 0, 16'h0040)),
            mk_out(1, 32'h10C, 5'h18, 5, 16'h0, 16'h0, 16'h0040, 1, 1, 0, 1, 2'b10, 0));
        add(mk_in(0, 1, 1, 6, 16'h6666, 32'h110, ins(5'h19, 0, 5, 1, 16'h0008)), bub(1, 0));
        add(mk_in(0, 0, 0, 0, 16'h0, 32'h200, ins(5'h19, 0, 5, 1, 16'h0008)),
            mk_out(1, 32'h200, 5'h19, 0, 16'h0, 16'h0, 16'h0008, 0, 0, 1, 1, 2'b10, 0));
        add(mk_in(0, 0, 1, 5, 16'hABCD, 32'h204, ins(5'h03, 6, 5, 3, 0)),
            mk_out(1, 32'h204, 5'h03, 6, 16'hABCD, 16'h1234, 16'h0, 1, 0, 0, 1, 2'b01, 0));
        add(mk_in(0, 0, 0, 0, 16'h0, 32'h206, ins(5'h1A, 7, 5, 3, 16'h7777)),
            mk_out(1, 32'h206, 5'h00, 7, 16'hABCD, 16'h1234, 16'h7777, 0, 0, 0, 1, 2'b10, 0));
        add(mk_in(0, 0, 0, 0, 16'h0, 32'h20A, ins(5'h08, 0, 3, 0, 0)),
            mk_out(1, 32'h20A, 5'h08, 0, 16'h1234, 16'h0, 16'h0, 0, 0, 0, 1, 2'b01, 0));
        add(mk_in(0, 0, 0, 0, 16'h0, 32'h20C, ins(5'h11, 1, 6, 0, 16'h00FF)),
            mk_out(1, 32'h20C, 5'h11, 1, 16'h6666, 16'h0, 16'h00FF, 1, 0, 0, 1, 2'b10, 0));
        add(mk_in(0, 0, 0, 0, 16'h0, 32'h210, ins(5'h0F, 0, 0, 0, 0)), bub(0, 1));

        foreach (tbl[k]) begin
            step(tbl[k].s, a);
            cmp_out($sformatf("vec%0d", k), a, tbl[k].e);
        end

        // Stuck in HALT for 10 cycles with flush pulses and writebacks
        for (int i = 0; i < 10; i++) begin
            step(mk_in(0, 1'(i % 2), 1, 7, 16'(i + 1), 32'h300, ins(5'h01, 1, 2, 3, 0)), a);
            cmp_out($sformatf("halt%0d", i), a, bub(0, 1));
        end
        step(mk_in(1, 1, 0, 0, 16'h0, 32'h300, ins(5'h01, 1, 7, 3, 0)), a);
        cmp_out("halt_rst", a, bub(0, 0));
        step(mk_in(0, 0, 0, 0, 16'h0, 32'h400, ins(5'h01, 1, 7, 3, 0)), a);
        cmp_out("post_rst", a,
                mk_out(1, 32'h400, 5'h01, 1, 16'h0, 16'h0, 16'h0, 1, 0, 0, 1, 2'b01, 0));

        // Random phase against the reference model
        m_cur = '0;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        for (int c = 0; c < 600; c++) begin
            s = mk_in((c == 0) || ($urandom_range(0, 39) == 0),
                      ($urandom_range(0, 7) == 0),
                      1'($urandom), 3'($urandom), 16'($urandom),
                      $urandom, rand_instr());
            model_step(s, e);
            step(s, a);
            cmp_out($sformatf("rnd%0d", c), a, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
